// File: rtl/gf180mcu_fd_sc_mcu7t5v0__descr7_chk.sv
// Serial self-synchronizing descrambler (x^7+x^6+1) with frame even-parity check,
// lock tracking and a saturating parity-error counter.
module gf180mcu_fd_sc_mcu7t5v0__descr7_chk #(
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned ERR_LIMIT = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic             D,
    input  logic             SOF,
    output logic             Q,
    output logic             QV,
    output logic             LOCK,
    output logic             PERR,
    output logic [CNT_W-1:0] PERR_CNT,
    inout  wire              VDD,
    inout  wire              VSS
);

    localparam int unsigned BIT_W  = $clog2(FRAME_LEN + 1);
    localparam int unsigned CONS_W = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT + 1);
    localparam int unsigned FILL_W = 3;
    localparam int unsigned SREG_W = 7;

    typedef enum logic {
        ST_FILL   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [SREG_W-1:0]   r_sreg,     w_sreg_nxt;
    logic [FILL_W-1:0]   r_fill_cnt, w_fill_nxt;
    logic                r_active,   w_active_nxt;
    logic [BIT_W-1:0]    r_bit_cnt,  w_bit_nxt;
    logic                r_parity,   w_parity_nxt;
    logic [CONS_W-1:0]   r_cons_cnt, w_cons_nxt;
    logic                r_q,        w_q_nxt;
    logic                r_qv,       w_qv_nxt;
    logic                r_lock,     w_lock_nxt;
    logic                r_perr,     w_perr_nxt;
    logic [CNT_W-1:0]    r_perr_cnt, w_perr_cnt_nxt;
    logic                w_d;

    // Supply pins carry no logic function in the RTL view.
    wire w_unused_supply;
    assign w_unused_supply = VDD ^ VSS;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state    <= ST_FILL;
            r_sreg     <= '0;
            r_fill_cnt <= '0;
            r_active   <= 1'b0;
            r_bit_cnt  <= '0;
            r_parity   <= 1'b0;
            r_cons_cnt <= '0;
            r_q        <= 1'b0;
            r_qv       <= 1'b0;
            r_lock     <= 1'b0;
            r_perr     <= 1'b0;
            r_perr_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sreg     <= w_sreg_nxt;
            r_fill_cnt <= w_fill_nxt;
            r_active   <= w_active_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_parity   <= w_parity_nxt;
            r_cons_cnt <= w_cons_nxt;
            r_q        <= w_q_nxt;
            r_qv       <= w_qv_nxt;
            r_lock     <= w_lock_nxt;
            r_perr     <= w_perr_nxt;
            r_perr_cnt <= w_perr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sreg_nxt     = r_sreg;
        w_fill_nxt     = r_fill_cnt;
        w_active_nxt   = r_active;
        w_bit_nxt      = r_bit_cnt;
        w_parity_nxt   = r_parity;
        w_cons_nxt     = r_cons_cnt;
        w_q_nxt        = r_q;
        w_qv_nxt       = 1'b0;
        w_lock_nxt     = r_lock;
        w_perr_nxt     = 1'b0;
        w_perr_cnt_nxt = r_perr_cnt;
        w_d            = D ^ r_sreg[6] ^ r_sreg[5];

        if (EN) begin
            // The line bit, not the recovered bit, feeds the history register.
            w_sreg_nxt = {r_sreg[5:0], D};
            w_q_nxt    = w_d;
            case (r_state)
                ST_FILL: begin
                    w_fill_nxt = r_fill_cnt + FILL_W'(1);
                    if (r_fill_cnt == FILL_W'(SREG_W - 1)) begin
                        w_state_nxt = ST_LOCKED;
                        w_lock_nxt  = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    w_qv_nxt = 1'b1;
                    if (SOF) begin
                        // A new SOF silently drops any partial frame.
                        w_active_nxt = 1'b1;
                        w_bit_nxt    = BIT_W'(1);
                        w_parity_nxt = w_d;
                    end else if (r_active) begin
                        if (r_bit_cnt == BIT_W'(FRAME_LEN - 1)) begin
                            w_active_nxt = 1'b0;
                            w_bit_nxt    = '0;
                            w_parity_nxt = 1'b0;
                            if (r_parity ^ w_d) begin
                                w_perr_nxt = 1'b1;
                                if (r_perr_cnt != '1) begin
                                    w_perr_cnt_nxt = r_perr_cnt + CNT_W'(1);
                                end
                                if (r_cons_cnt != '1) begin
                                    w_cons_nxt = r_cons_cnt + CONS_W'(1);
                                end
                                if ((ERR_LIMIT != 0) &&
                                    (32'(r_cons_cnt) + 32'd1 >= ERR_LIMIT)) begin
                                    w_state_nxt = ST_FILL;
                                    w_lock_nxt  = 1'b0;
                                    w_fill_nxt  = '0;
                                    w_cons_nxt  = '0;
                                end
                            end else begin
                                w_cons_nxt = '0;
                            end
                        end else begin
                            w_bit_nxt    = r_bit_cnt + BIT_W'(1);
                            w_parity_nxt = r_parity ^ w_d;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_FILL;
                end
            endcase
        end
    end

    assign Q        = r_q;
    assign QV       = r_qv;
    assign LOCK     = r_lock;
    assign PERR     = r_perr;
    assign PERR_CNT = r_perr_cnt;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__descr7_chk.sv
// Directed scoreboard bench for the x^7+x^6+1 descrambler / frame parity checker.
module tb_gf180mcu_fd_sc_mcu7t5v0__descr7_chk;

    localparam int FL = 16;

    logic       CLK = 1'b0;
    logic       RN  = 1'b0;
    logic       rn2 = 1'b0;
    logic       EN  = 1'b0;
    logic       D   = 1'b0;
    logic       SOF = 1'b0;
    wire        vdd = 1'b1;
    wire        vss = 1'b0;

    logic       q, qv, lock, perr;
    logic [7:0] perr_cnt;
    logic       s_q, s_qv, s_lock, s_perr;
    logic [1:0] s_perr_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic q;
        logic qv;
        logic perr;
        logic chk_q;
    } exp_t;

    exp_t       sb[$];
    logic [6:0] hist = '0;
    logic       last_q = 1'b0;
    logic       q_known = 1'b0;

    gf180mcu_fd_sc_mcu7t5v0__descr7_chk #(.FRAME_LEN(16), .ERR_LIMIT(4), .CNT_W(8)) u_dut (
        .CLK(CLK), .RN(RN), .EN(EN), .D(D), .SOF(SOF),
        .Q(q), .QV(qv), .LOCK(lock), .PERR(perr), .PERR_CNT(perr_cnt),
        .VDD(vdd), .VSS(vss)
    );

    gf180mcu_fd_sc_mcu7t5v0__descr7_chk #(.FRAME_LEN(16), .ERR_LIMIT(0), .CNT_W(2)) u_sat (
        .CLK(CLK), .RN(rn2), .EN(EN), .D(D), .SOF(SOF),
        .Q(s_q), .QV(s_qv), .LOCK(s_lock), .PERR(s_perr), .PERR_CNT(s_perr_cnt),
        .VDD(vdd), .VSS(vss)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push its expectation, then pop and compare after the edge.
    task automatic step(input logic en, input logic d, input logic sof,
                        input logic e_qv, input logic e_perr);
        exp_t e;
        EN = en; D = d; SOF = sof;
        e.qv = e_qv;
        e.perr = e_perr;
        if (en) begin
            e.q = d ^ hist[6] ^ hist[5];
            hist = {hist[5:0], d};
            last_q = e.q;
            e.chk_q = e_qv;
            if (e_qv) q_known = 1'b1;
        end else begin
            e.q = last_q;
            e.chk_q = q_known;
        end
        sb.push_back(e);
        @(posedge CLK); #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL scoreboard: observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            chk("qv", 32'(qv), 32'(e.qv));
            chk("perr", 32'(perr), 32'(e.perr));
            if (e.chk_q) chk("q", 32'(q), 32'(e.q));
        end
    endtask

    // One framed burst of ones; a single line zero at 'bad' (or none if negative).
    task automatic frame(input int bad, input logic fail);
        for (int i = 0; i < FL; i++)
            step(1'b1, (i == bad) ? 1'b0 : 1'b1, (i == 0), 1'b1, fail && (i == FL - 1));
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_q", 32'(q), 0);
        chk("rst_qv", 32'(qv), 0);
        chk("rst_lock", 32'(lock), 0);
        chk("rst_perr", 32'(perr), 0);
        chk("rst_cnt", 32'(perr_cnt), 0);
        RN = 1'b1;

        // Initial fill with constant ones
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 5) chk("fill_lock6", 32'(lock), 0);
            if (i == 6) chk("fill_lock7", 32'(lock), 1);
        end
        frame(-1, 1'b0);
        chk("good_cnt", 32'(perr_cnt), 0);

        // Four consecutive corrupted frames drop lock on the fourth
        for (int k = 1; k <= 4; k++) begin
            frame(2, 1'b1);
            chk("bad_cnt", 32'(perr_cnt), 32'(k));
            chk("bad_lock", 32'(lock), (k < 4) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 5) chk("refill_lock6", 32'(lock), 0);
            if (i == 6) chk("refill_lock7", 32'(lock), 1);
        end
        frame(-1, 1'b0);
        chk("relock_cnt", 32'(perr_cnt), 4);

        // SOF restart at bit 9: old boundary unchecked, new frame fails 16 bits on
        for (int t = 0; t < 25; t++)
            step(1'b1, (t == 12) ? 1'b0 : 1'b1, (t == 0) || (t == 9), 1'b1, (t == 24));
        chk("resof_cnt", 32'(perr_cnt), 5);
        chk("resof_lock", 32'(lock), 1);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, (i == 0), 1'b1, 1'b0);
        #2;
        RN = 1'b0;
        #1;
        chk("arst_q", 32'(q), 0);
        chk("arst_qv", 32'(qv), 0);
        chk("arst_lock", 32'(lock), 0);
        chk("arst_cnt", 32'(perr_cnt), 0);
        @(posedge CLK); #1;
        RN = 1'b1;
        hist = '0;
        q_known = 1'b0;
        last_q = 1'b0;

        // EN toggling: lock after 7 enabled bits = 13 clocks
        for (int i = 0; i < 13; i++) begin
            step((i % 2) == 0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 11) chk("tog_lock12", 32'(lock), 0);
            if (i == 12) chk("tog_lock13", 32'(lock), 1);
        end
        for (int i = 0; i < 4; i++)
            step((i % 2) == 1, 1'b1, 1'b0, (i % 2) == 1, 1'b0);
        chk("tog_cnt", 32'(perr_cnt), 0);

        // Saturating counter instance with unlock disabled
        RN = 1'b0;
        rn2 = 1'b1;
        EN = 1'b1; D = 1'b1; SOF = 1'b0;
        repeat (7) @(posedge CLK);
        #1;
        chk("sat_fill_lock", 32'(s_lock), 1);
        for (int k = 1; k <= 5; k++) begin
            for (int i = 0; i < FL; i++) begin
                D = (i == 2) ? 1'b0 : 1'b1;
                SOF = (i == 0);
                @(posedge CLK); #1;
                if (i == FL - 2) chk("sat_perr_pre", 32'(s_perr), 0);
            end
            chk("sat_perr", 32'(s_perr), 1);
            chk("sat_cnt", 32'(s_perr_cnt), (k < 3) ? 32'(k) : 32'd3);
            chk("sat_lock", 32'(s_lock), 1);
        end
        EN = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__descr7_chk.md
Name: gf180mcu_fd_sc_mcu7t5v0__descr7_chk

Overview:
- Serial self-synchronizing descrambler (polynomial x^7+x^6+1) with frame even-parity checker.
- Receive-side counterpart of the library's XOR-based scrambler/parity-encoder path.
- Recovers plain data from the scrambled bit stream, reports lock, and flags frames whose even parity fails.
- Sits between the serial line sampler and the frame deframer.

Parameters:
- FRAME_LEN, 16, bits per frame including the trailing parity bit; legal range 2..256.
- ERR_LIMIT, 4, consecutive failed frames that force loss of lock; 0 disables unlock.
- CNT_W, 8, width of the saturating parity-error counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RN  input  1  asynchronous active-low reset.
- EN  input  1  input-bit valid; state advances only when EN=1.
- D  input  1  received scrambled bit.
- SOF  input  1  start-of-frame marker; qualified by EN, aligned with the first bit of the frame.
- Q  output  1  descrambled bit, registered.
- QV  output  1  Q valid strobe.
- LOCK  output  1  descrambler register filled and frames passing.
- PERR  output  1  one-cycle pulse on a failed frame parity check.
- PERR_CNT  output  CNT_W  saturating count of failed frames.
- VDD  inout  1  supply.
- VSS  inout  1  ground.

Behaviour:
- Reset (RN=0, asynchronous, effective immediately, mid-operation included) clears all state and outputs:
  - sreg[6:0]=0, fill count=0, state=FILL, frame active=0, bit count=0, parity=0, consecutive-error count=0.
  - Q=0, QV=0, LOCK=0, PERR=0, PERR_CNT=0.
- Datapath, on each edge with EN=1:
  - d = D ^ sreg[6] ^ sreg[5].
  - sreg <= {sreg[5:0], D}. The received bit, not d, is shifted in.
- Latency: Q and QV are registered one edge after the bit is sampled.
- EN=0: sreg and counters hold, QV=0, Q holds, PERR=0.
- State FILL:
  - Each EN bit increments the fill count; QV stays 0; SOF is ignored.
  - On the 7th EN bit: state becomes LOCKED and LOCK=1 at that edge.
  - The 8th bit is the first with QV=1.
- State LOCKED:
  - Every EN bit produces QV=1.
  - Bits outside a frame are not checked.
- Frame start:
  - An EN bit with SOF=1 starts a frame: bit count=1, parity=d.
  - SOF on any bit of an active frame discards the partial frame with no check, then starts a new frame on that bit.
- Frame accumulation:
  - Each later EN bit in the frame sets parity^=d and increments the bit count.
  - On the bit where the count reaches FRAME_LEN, evaluate final parity (accumulated parity ^ d) and end the frame.
- Check pass (final parity 0): PERR=0; consecutive-error count=0.
- Check fail (final parity 1):
  - PERR=1 in the same cycle as QV for that last bit; it lasts one cycle.
  - PERR_CNT increments and saturates at 2^CNT_W-1.
  - The consecutive-error count increments.
- Loss of lock:
  - When ERR_LIMIT!=0 and the consecutive-error count reaches ERR_LIMIT, on the same edge: state=FILL, LOCK=0, fill count=0, frame inactive.
  - sreg is not cleared; PERR_CNT is kept.
  - Refill takes 7 further EN bits.
- Single-bit line errors appear three times in Q, at offsets 0, +6 and +7 bits. Parity fails only if an odd number of those three fall within one frame.

Test Plan:
- Reset, then EN=1, D=1 constant:
  - LOCK=1 after the 7th edge.
  - First QV=1 for the 8th bit, with Q=1; Q stays 1 thereafter.
- Locked with D=1, SOF on bit 0, FRAME_LEN=16:
  - Q is sixteen ones, so PERR=0 and PERR_CNT=0.
  - Flip D=0 at frame bit 2: Q=0 at bits 2, 8 and 9, giving three errors, so PERR=1 on bit 15 and PERR_CNT=1.
- ERR_LIMIT=4, four consecutive corrupted frames as above:
  - PERR pulses four times.
  - LOCK=0 at the 4th fail edge; PERR_CNT=4.
  - LOCK returns 7 EN bits later.
- SOF reasserted at bit 9 of a 16-bit frame:
  - No check and no PERR at the old boundary.
  - Check occurs 16 bits after the new SOF.
- EN toggling 1/0 each cycle with D=1 after reset:
  - LOCK after 7 EN=1 cycles, i.e. 13 clocks.
  - QV=0 in every EN=0 cycle.
- RN pulsed low mid-frame:
  - All outputs 0 immediately, without waiting for a CLK edge.
  - PERR_CNT=0; the fill restarts from 0.
- CNT_W=2, ERR_LIMIT=0, five failing frames:
  - PERR_CNT saturates at 3.
  - LOCK remains 1.
